// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Latency: XLEN+1 cycles from the accepting edge to the done pulse; busy high throughout.
// Backpressure: no handshake; busy stalls the pipeline, start while busy is ignored, cancel aborts.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, op         launch an operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   rs_val, rt_val    multiplicand/dividend, multiplier/divisor (captured at the accepting edge)
//   cancel            pipeline flush; drops the operation in flight
//   mthi, mtlo        write wr_data into HI / LO while idle
//   hi, lo            architectural HI/LO registers
//   busy              operation in progress
//   done              one-cycle pulse when HI/LO hold a new result
//   div_by_zero       one-cycle pulse alongside done for a zero divisor
module mdu_hilo #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            cancel,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic              is_div;     // captured op[1]
  logic              sign_a;     // dividend / multiplicand was negative (signed ops only)
  logic              sign_b;     // divisor / multiplier was negative (signed ops only)
  logic [XLEN-1:0]   op_a;       // magnitude of rs
  logic [XLEN-1:0]   op_b;       // magnitude of rt
  logic [XLEN-1:0]   raw_a;      // rs as given, returned in HI on divide by zero
  logic [2*XLEN-1:0] acc;        // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              in_signed;
  logic              rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_mag, rt_mag;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_step;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   res_hi, res_lo;
  logic              b_zero;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !cancel) state_nxt = CALC;
      CALC:    if (cancel) state_nxt = IDLE;
               else if (cnt == CNT_W'(XLEN-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // ---------------------------------------------------------------- operand capture
  assign accept    = (state == IDLE) && start && !cancel;
  assign in_signed = ~op[0];
  assign rs_neg    = in_signed & rs_val[XLEN-1];
  assign rt_neg    = in_signed & rt_val[XLEN-1];
  assign rs_mag    = rs_neg ? (~rs_val + XLEN'(1)) : rs_val;
  assign rt_mag    = rt_neg ? (~rt_val + XLEN'(1)) : rt_val;

  // ---------------------------------------------------------------- one radix-2 step
  always_comb begin
    // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_a} : '0);
    // Restoring divide: shift next dividend bit into the remainder and try to subtract.
    // The remainder stays below the divisor, so a successful difference fits in XLEN bits.
    div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = (div_trial >= {1'b0, op_b});
    div_diff  = div_trial[XLEN-1:0] - op_b;
    if (is_div)
      acc_step = {(div_ge ? div_diff : div_trial[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  // ---------------------------------------------------------------- sign correction
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? (~acc + (2*XLEN)'(1)) : acc;
    quo      = acc[XLEN-1:0];
    rem      = acc[2*XLEN-1:XLEN];
    b_zero   = (op_b == '0);
    if (is_div) begin
      if (b_zero) begin
        res_hi = raw_a;
        res_lo = '1;
      end else begin
        // Remainder follows the dividend; quotient negates on differing signs.
        // The most negative dividend over -1 naturally wraps back to itself.
        res_hi = sign_a            ? (~rem + XLEN'(1)) : rem;
        res_lo = (sign_a ^ sign_b) ? (~quo + XLEN'(1)) : quo;
      end
    end else begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
    end
  end

  // ---------------------------------------------------------------- datapath and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      raw_a       <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          // Moves land now even alongside a start; the later FIX overwrites them.
          if (mthi) hi <= wr_data;
          if (mtlo) lo <= wr_data;
          if (accept) begin
            is_div <= op[1];
            sign_a <= rs_neg;
            sign_b <= rt_neg;
            op_a   <= rs_mag;
            op_b   <= rt_mag;
            raw_a  <= rs_val;
            cnt    <= '0;
            acc    <= op[1] ? {{XLEN{1'b0}}, rs_mag} : {{XLEN{1'b0}}, rt_mag};
          end
        end
        CALC: begin
          if (!cancel) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (!cancel) begin
            hi          <= res_hi;
            lo          <= res_lo;
            done        <= 1'b1;
            div_by_zero <= is_div && b_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
